key_uart_tx: RTL and testbench
==============================

KEY_UART_TX -- requirements
Module: key_uart_tx

Interface
REQ-001 Parameter CLK_HZ, default 24000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate; DIV = CLK_HZ/BAUD (integer, truncated), SHALL be >= 2.
REQ-003 Parameter FIFO_DEPTH, default 8, byte entries; SHALL be a power of two, >= 2.
REQ-004 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 data  input  8  keystroke byte from the keyboard stage.
REQ-007 valid  input  1  data holds a byte to accept.
REQ-008 ready  output  1  block can accept a byte this cycle.
REQ-009 tx  output  1  serial line, idle high.
REQ-010 busy  output  1  frame in progress or FIFO non-empty.

Function
REQ-011 ready SHALL equal !fifo_full, combinationally from registered state only; it SHALL NOT depend on valid.
REQ-012 A byte SHALL be written on a rising edge where valid && ready; data is sampled on that edge.
REQ-013 When valid is high and ready is low, the byte SHALL NOT be written and the upstream stage holds it.
REQ-014 FIFO: read/write pointers with one extra wrap bit; full when the indices match and the wrap bits differ; empty when the pointers are equal; pointers wrap modulo FIFO_DEPTH.
REQ-015 Transmitter FSM states: IDLE, START, DATA, PARITY (only when configured), STOP.
REQ-016 IDLE with FIFO non-empty: pop the head into the shift register, go to START, drive tx=0, and clear the baud counter, all on the same edge.
REQ-017 Latency: a byte pushed into an empty FIFO with FSM in IDLE SHALL drive tx low exactly 1 cycle after the push edge.
REQ-018 Each bit SHALL last exactly DIV cycles; the baud counter counts 0..DIV-1 and a bit ends when it reaches DIV-1.
REQ-019 DATA SHALL send 8 bits LSB first; a 3-bit index counts 0..7.
REQ-020 STOP SHALL drive tx=1 for DIV cycles, then go to IDLE.
REQ-021 If the FIFO is non-empty when STOP ends, the next START SHALL begin on the following edge, with no extra idle bit time.
REQ-022 Simultaneous push and pop in one cycle SHALL both happen; occupancy is unchanged.
REQ-023 If a push and a pop occur on the same edge while the FIFO is full, the pop SHALL proceed and no push SHALL occur, because ready was low.
REQ-024 busy SHALL equal (state != IDLE) || !fifo_empty.

Reset
REQ-025 Reset asserted: state=IDLE, tx=1, FIFO pointers=0, baud counter=0, bit index=0, shift register=0; ready=1 and busy=0 follow from these values.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, with tx high asynchronously, and SHALL discard all queued bytes.
REQ-027 Reset deassertion SHALL be honoured on the next clk edge; no frame SHALL start on that edge.

Configuration
REQ-028 Macro UART_PARITY_EN defined: PARITY state after DATA sends the even-parity bit (XOR of the 8 data bits) for DIV cycles; frame is 11 bit times.
REQ-029 UART_PARITY_EN undefined: the PARITY state and its logic SHALL be absent; DATA goes directly to STOP; frame is 10 bit times.

Structure
REQ-030 Package key_uart_pkg SHALL hold the FSM state encoding, the frame-length constant, and a DIV computation function.
REQ-031 Sub-module key_fifo (sync FIFO, parameter DEPTH, push/pop/full/empty/dout) SHALL implement the FIFO; the transmitter FSM SHALL stay in key_uart_tx.

Verification (bench: CLK_HZ=16, BAUD=1, so DIV=16)
REQ-032 Single byte 0x41 into an idle block -> tx low 1 cycle after the push for 16 cycles, then bits 1,0,0,0,0,0,1,0 (16 cycles each), then stop high for 16 cycles; busy low after the stop.
REQ-033 Push 0x0D then 0x0A back-to-back -> two frames; second start bit begins on the cycle right after the first stop's 16th cycle.
REQ-034 Push 9 bytes without gaps, FIFO_DEPTH=8 -> ready low after the 9th byte lands (8 queued plus 1 in the shifter); the 10th byte is held until the first pop.
REQ-035 reset asserted in the middle of data bit 3 of 0x55 -> tx=1 at once; after release, busy=0, ready=1, and no frame is sent.
REQ-036 UART_PARITY_EN defined, byte 0x07 -> parity bit 1, frame 176 cycles; byte 0x03 -> parity bit 0.
REQ-037 valid held high while ready is low, with data changing -> only the bytes present on accepted edges are sent, and in push order.

Source files
------------

// File: rtl/key_uart_pkg.sv
// key_uart_pkg -- shared definitions for the keystroke UART transmitter.
//
// Contents:
//   tx_state_t   transmitter FSM state encoding
//   FRAME_BITS   bit times per frame (start + 8 data [+ parity] + stop)
//   calc_div     clock cycles per bit from CLK_HZ and BAUD (truncated)
//   even_parity  even-parity bit of one data byte
//
// Optional feature macro: UART_PARITY_EN (adds the even-parity bit).
package key_uart_pkg;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int FRAME_BITS = 11;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } tx_state_t;

    localparam int FRAME_BITS = 10;
`endif

    // Integer division truncates, matching the bit-period definition.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // XOR of all data bits: 1 when the byte holds an odd number of ones.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// key_fifo -- synchronous byte FIFO with wrap-bit pointers.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset, clears both pointers
//   push   in   write din this edge (ignored while full)
//   pop    in   advance the read pointer this edge (ignored while empty)
//   din    in   [7:0] byte to write
//   dout   out  [7:0] head entry (valid while !empty)
//   full   out  DEPTH entries held
//   empty  out  no entries held
//
// DEPTH must be a power of two >= 2 so the index bits wrap naturally.
module key_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [7:0]  mem_r [DEPTH];
    logic        do_push_s;
    logic        do_pop_s;

    // Same index with different wrap bits means the writer lapped the reader.
    assign full  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign dout  = mem_r[rd_ptr_r[AW-1:0]];

    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Pointer update; push and pop on the same edge both take effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/key_uart_tx.sv
// key_uart_tx -- buffered 8N1 (or 8E1) UART transmitter for keystroke bytes.
//
// Parameters: CLK_HZ (system clock Hz), BAUD (bit rate), FIFO_DEPTH (bytes).
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset; aborts any frame, empties FIFO
//   data   in   [7:0] keystroke byte
//   valid  in   data holds a byte to accept
//   ready  out  byte accepted on this edge if valid (equals !fifo_full)
//   tx     out  serial line, idle high, registered
//   busy   out  frame in progress or bytes still queued
//
// Optional feature macro: UART_PARITY_EN (even-parity bit between data and stop).
module key_uart_tx
    import key_uart_pkg::*;
#(
    parameter int CLK_HZ     = 24000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int               DIV       = calc_div(CLK_HZ, BAUD);
    localparam int               CNT_W     = $clog2(DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

    tx_state_t        state_r;
    logic [CNT_W-1:0] baud_cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             tx_r;

    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [7:0]       fifo_dout_s;
    logic             push_s;
    logic             pop_s;
    logic             bit_end_s;

    key_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (data),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign ready     = !fifo_full_s;
    assign push_s    = valid && !fifo_full_s;
    assign bit_end_s = (baud_cnt_r == BAUD_LAST);
    assign busy      = (state_r != ST_IDLE) || !fifo_empty_s;
    assign tx        = tx_r;

    // Pop decision: from IDLE, or straight out of the last stop cycle so
    // back-to-back frames have no idle gap between them.
    always_comb begin
        pop_s = 1'b0;
        if (!fifo_empty_s) begin
            if (state_r == ST_IDLE) begin
                pop_s = 1'b1;
            end else if ((state_r == ST_STOP) && bit_end_s) begin
                pop_s = 1'b1;
            end else begin
                pop_s = 1'b0;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // Transmitter FSM; tx is registered and changes on the state-entry edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= {CNT_W{1'b0}};
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            tx_r       <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        shift_r    <= fifo_dout_s;
                        baud_cnt_r <= {CNT_W{1'b0}};
                        bit_idx_r  <= 3'd0;
                        tx_r       <= 1'b0;
                        state_r    <= ST_START;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= {CNT_W{1'b0}};
                        bit_idx_r  <= 3'd0;
                        tx_r       <= shift_r[0];
                        state_r    <= ST_DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= {CNT_W{1'b0}};
                        if (bit_idx_r == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx_r    <= even_parity(shift_r);
                            state_r <= ST_PARITY;
`else
                            tx_r    <= 1'b1;
                            state_r <= ST_STOP;
`endif
                        end else begin
                            // Shift register is left intact so parity can use it.
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= shift_r[bit_idx_r + 3'd1];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_W'(1);
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= {CNT_W{1'b0}};
                        tx_r       <= 1'b1;
                        state_r    <= ST_STOP;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= {CNT_W{1'b0}};
                        bit_idx_r  <= 3'd0;
                        if (pop_s) begin
                            shift_r <= fifo_dout_s;
                            tx_r    <= 1'b0;
                            state_r <= ST_START;
                        end else begin
                            tx_r    <= 1'b1;
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    baud_cnt_r <= {CNT_W{1'b0}};
                    bit_idx_r  <= 3'd0;
                    tx_r       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_uart_tx.sv
// tb_key_uart_tx -- self-checking bench for key_uart_tx (CLK_HZ=16, BAUD=1).
// Reference: a queue of accepted bytes plus the position inside the current
// frame; the expected line level is derived from that position each cycle.
module tb_key_uart_tx;

    localparam int DIV   = 16;
    localparam int DEPTH = 8;
`ifdef UART_PARITY_EN
    localparam int FRAME = 11;
    localparam bit PAR   = 1'b1;
`else
    localparam int FRAME = 10;
    localparam bit PAR   = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;

    int tests;
    int fails;

    // Reference model state
    logic [7:0] q[$];
    bit         m_busy;
    int         m_cyc;
    logic [7:0] m_cur;

    key_uart_tx #(
        .CLK_HZ     (16),
        .BAUD       (1),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .tx    (tx),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic exp_tx();
        int b;
        if (!m_busy) return 1'b1;
        b = m_cyc / DIV;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        if (PAR && b == 9) return ^m_cur;
        return 1'b1;
    endfunction

    function automatic logic exp_ready();
        return (q.size() < DEPTH) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic exp_busy();
        return (m_busy || q.size() > 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_busy = 1'b0;
        m_cyc  = 0;
        m_cur  = 8'h00;
    endtask

    // One rising edge of the reference: start/advance/finish frame, then accept.
    task automatic model_edge(input logic v, input logic [7:0] d);
        bit acc;
        acc = v && (q.size() < DEPTH);
        if (!m_busy) begin
            if (q.size() > 0) begin
                m_cur  = q.pop_front();
                m_cyc  = 0;
                m_busy = 1'b1;
            end
        end else begin
            m_cyc++;
            if (m_cyc == FRAME * DIV) begin
                if (q.size() > 0) begin
                    m_cur = q.pop_front();
                    m_cyc = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end
        end
        if (acc) q.push_back(d);
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        @(negedge clk);
        valid = v;
        data  = d;
        #1;
        check("ready_pre", ready, exp_ready());
        @(posedge clk);
        model_edge(v, d);
        #1;
        check("tx", tx, exp_tx());
        check("busy", busy, exp_busy());
        check("ready", ready, exp_ready());
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (!m_busy && q.size() == 0) break;
            step(1'b0, 8'h00);
        end
        step(1'b0, 8'h00);
        check("drain_busy", busy, 1'b0);
        check("drain_tx", tx, 1'b1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", ready, 1'b1);
        reset = 1'b1;
        repeat (4) step(1'b0, 8'h00);

        // Single byte 0x41
        step(1'b1, 8'h41);
        drain();

        // Back-to-back 0x0D, 0x0A
        step(1'b1, 8'h0D);
        step(1'b1, 8'h0A);
        drain();

`ifdef UART_PARITY_EN
        step(1'b1, 8'h07);
        drain();
        step(1'b1, 8'h03);
        drain();
`endif

        // Nine-byte burst fills FIFO; then valid held high with changing data
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h30 + i));
        check("full_after_9", ready, 1'b0);
        for (int i = 0; i < 400; i++) step(1'b1, 8'($urandom));
        drain();

        // Reset in the middle of data bit 3 of 0x55
        step(1'b1, 8'h55);
        for (int i = 0; i < 200; i++) begin
            if (m_busy && m_cyc >= 4 * DIV + DIV / 2) break;
            step(1'b0, 8'h00);
        end
        @(negedge clk);
        valid = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", ready, 1'b1);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3 * DIV; i++) step(1'b0, 8'h00);

        // Randomized traffic with random gaps
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0, 8'($urandom));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
